// File: rtl/nibble_packer.sv
// Packs a stream of NIBBLE_W-bit nibbles into NIBBLES-nibble words; nibble 0 lands in the LSBs.
// Optional partial-word flush is compiled in when PACKER_FLUSH_EN is defined.
module nibble_packer #(
  parameter  int NIBBLE_W = 4,
  parameter  int NIBBLES  = 4,
  localparam int WORD_W   = NIBBLE_W * NIBBLES,
  localparam int FILL_W   = $clog2(NIBBLES) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NIBBLE_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
`ifdef PACKER_FLUSH_EN
  input  logic                flush,
  output logic                out_partial,
`endif
  output logic [WORD_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FILL_W-1:0]   fill
);

  logic [FILL_W-1:0] r_fill;
  logic [WORD_W-1:0] r_acc;
  logic [WORD_W-1:0] r_out_data;
  logic              r_out_valid;

  logic              w_accept;
  logic              w_last;
  logic              w_complete;
  logic              w_slot_free;
  logic              w_flush_emit;
  logic              w_flush_block;
  logic [WORD_W-1:0] w_acc_ins;

  assign w_last      = (r_fill == FILL_W'(NIBBLES - 1));
  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = !(w_last && !w_slot_free) && !w_flush_block;
  assign w_accept    = in_valid && in_ready;
  assign w_complete  = w_accept && w_last;

  // Accumulator with the incoming nibble dropped into its slot; feeds both storage and output.
  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_ins
      assign w_acc_ins[gi*NIBBLE_W +: NIBBLE_W] =
        (w_accept && (r_fill == FILL_W'(gi))) ? in_data : r_acc[gi*NIBBLE_W +: NIBBLE_W];
    end
  endgenerate

`ifdef PACKER_FLUSH_EN
  logic r_flush_pend;
  logic r_out_partial;
  logic w_flush_req;
  logic w_has_data;
  logic w_flush_pend_next;

  // A flush that cannot emit yet (slot occupied) is remembered and stalls input until it goes out.
  assign w_flush_req       = flush || r_flush_pend;
  assign w_has_data        = (r_fill != '0) || w_accept;
  assign w_flush_emit      = w_flush_req && w_has_data && !w_complete && w_slot_free;
  assign w_flush_pend_next = w_flush_req && w_has_data && !w_complete && !w_slot_free;
  assign w_flush_block     = r_flush_pend && !w_slot_free;
  assign out_partial       = r_out_partial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_pend  <= 1'b0;
      r_out_partial <= 1'b0;
    end else begin
      r_flush_pend <= w_flush_pend_next;
      if (w_complete || w_flush_emit) begin
        r_out_partial <= w_flush_emit;
      end else if (r_out_valid && out_ready) begin
        r_out_partial <= 1'b0;
      end
    end
  end
`else
  assign w_flush_emit  = 1'b0;
  assign w_flush_block = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill      <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_complete || w_flush_emit) begin
      // A new word may replace one being consumed this same cycle, keeping output gap-free.
      r_out_data  <= w_acc_ins;
      r_out_valid <= 1'b1;
      r_fill      <= '0;
      r_acc       <= '0;
    end else begin
      if (w_accept) begin
        r_acc  <= w_acc_ins;
        r_fill <= r_fill + FILL_W'(1);
      end
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign fill      = r_fill;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed self-checking bench for nibble_packer; flush cases run when PACKER_FLUSH_EN is defined.
module tb_nibble_packer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fill;
`ifdef PACKER_FLUSH_EN
  logic        flush;
  logic        out_partial;
`endif

  int n_cmp;
  int n_err;

  nibble_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef PACKER_FLUSH_EN
    .flush     (flush),
    .out_partial(out_partial),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill      (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] n);
    in_valid = 1'b1;
    in_data  = n;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_data   = 4'h0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
`ifdef PACKER_FLUSH_EN
    flush     = 1'b0;
`endif
    #12;
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // F,F,3,C -> C3FF for exactly one cycle
    send(4'hF); send(4'hF); send(4'h3);
    chk("t1_fill3", 32'(fill), 32'd3);
    send(4'hC);
    chk("t1_data", 32'(out_data), 32'hC3FF);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_fill0", 32'(fill), 32'd0);
    tick();
    chk("t1_valid_drop", 32'(out_valid), 32'd0);

    // Eight nibbles back to back: words 4 cycles apart, no stall
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i + 1);
      chk($sformatf("t2_in_ready%0d", i), 32'(in_ready), 32'd1);
      tick();
      chk($sformatf("t2_valid%0d", i), 32'(out_valid), ((i == 3) || (i == 7)) ? 32'd1 : 32'd0);
      if (i == 3) chk("t2_word0", 32'(out_data), 32'h4321);
      if (i == 7) chk("t2_word1", 32'(out_data), 32'h8765);
    end
    in_valid = 1'b0;
    tick();
    chk("t2_valid_end", 32'(out_valid), 32'd0);

    // Backpressure: first word held, completing nibble stalls until the slot frees
    out_ready = 1'b0;
    send(4'h1); send(4'h2); send(4'h3); send(4'h4);
    chk("t3_word0", 32'(out_data), 32'h4321);
    send(4'h5); send(4'h6); send(4'h7);
    chk("t3_fill3", 32'(fill), 32'd3);
    chk("t3_held_data", 32'(out_data), 32'h4321);
    in_valid = 1'b1;
    in_data  = 4'h8;
    chk("t3_stall", 32'(in_ready), 32'd0);
    tick();
    chk("t3_still_fill3", 32'(fill), 32'd3);
    chk("t3_still_held", 32'(out_data), 32'h4321);
    chk("t3_still_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("t3_unstall", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t3_word1", 32'(out_data), 32'h8765);
    chk("t3_word1_valid", 32'(out_valid), 32'd1);
    tick();
    chk("t3_drain", 32'(out_valid), 32'd0);

    // Reset mid-word discards partial data
    send(4'hA); send(4'hB);
    chk("t4_fill2", 32'(fill), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_fill", 32'(fill), 32'd0);
    chk("t4_rst_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(4'h1); send(4'h2); send(4'h3); send(4'h4);
    chk("t4_word", 32'(out_data), 32'h4321);
    chk("t4_valid", 32'(out_valid), 32'd1);
    tick();

`ifdef PACKER_FLUSH_EN
    // Partial flush of 5,6
    send(4'h5); send(4'h6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("f1_data", 32'(out_data), 32'h0065);
    chk("f1_partial", 32'(out_partial), 32'd1);
    chk("f1_valid", 32'(out_valid), 32'd1);
    chk("f1_fill", 32'(fill), 32'd0);
    // Flush with nothing held emits nothing
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("f2_no_out", 32'(out_valid), 32'd0);
    // Flush coinciding with the completing nibble is a normal word
    send(4'h9); send(4'h9); send(4'h9);
    flush = 1'b1;
    send(4'h9);
    flush = 1'b0;
    chk("f3_data", 32'(out_data), 32'h9999);
    chk("f3_partial", 32'(out_partial), 32'd0);
    chk("f3_valid", 32'(out_valid), 32'd1);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
